// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: digit encoding, scan constants and leading-zero suppression
package sevenseg_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic       dash;
        logic [3:0] val;
    } digit_t;

    localparam digit_t BLANK_DIGIT = 7'b100_0000;
    localparam int     PWM_SLOTS   = 16;
    localparam int     MAX_DIG     = 16;

    typedef digit_t [MAX_DIG-1:0] digit_arr_t;

    // Blank every digit above 0 that belongs to an unbroken run of plain zeros reaching the top digit.
    function automatic digit_arr_t lz_suppress(input digit_arr_t d, input int n);
        digit_arr_t r;
        logic       run;
        r   = d;
        run = 1'b1;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < n) begin
                if (run && d[i] == '0) r[i] = BLANK_DIGIT;
                else run = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_ext_n.sv
// sevenseg_ext_n: hex/dash/dp glyph decoder with active-low outputs (bit 0 = a .. bit 6 = g)
module sevenseg_ext_n
    import sevenseg_pkg::*;
(
    input  digit_t     dig_i,
    output logic [6:0] segs_n_o,
    output logic       dp_n_o
);

    localparam logic [15:0][6:0] HEX_N = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Blank overrides dash, dash overrides the hex glyph; dp never shows on a blank digit.
    always_comb begin
        segs_n_o = dig_i.blank ? 7'h7F : dig_i.dash ? 7'h3F : HEX_N[dig_i.val];
        dp_n_o   = ~(dig_i.dp & ~dig_i.blank);
    end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// sevenseg_scan_ctl: multiplexed seven-segment scanner with PWM, blink, zero blanking and frame snapshots
module sevenseg_scan_ctl
    import sevenseg_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int DWELL_US = 1000,
    parameter int BLINK_MS = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7*NDIG-1:0] digits,
    input  logic [3:0]        bright,
    input  logic [NDIG-1:0]   blink_en,
    input  logic              lz_en,
    output logic [6:0]        segs_n,
    output logic              dp_n,
    output logic [NDIG-1:0]   an_n,
    output logic              frame_tick
);

    localparam int DWELL    = int'(longint'(CLK_HZ) * DWELL_US / 1_000_000);
    localparam int BLINK    = int'(longint'(CLK_HZ) * BLINK_MS / 1000);
    localparam int SLOT_LEN = DWELL / PWM_SLOTS;
    localparam int SW       = SLOT_LEN > 1 ? $clog2(SLOT_LEN) : 1;
    localparam int BW       = BLINK > 1 ? $clog2(BLINK) : 1;
    localparam int IW       = $clog2(NDIG);
    localparam int DW       = 7 * NDIG;

    logic [SW-1:0]          sub_q, sub_d;
    logic [3:0]             slot_q, slot_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   phase_q, phase_d;
    logic                   valid_q, valid_d;
    digit_t [NDIG-1:0]      snap_q, snap_d;
    logic [6:0]             segs_n_q, segs_n_d;
    logic                   dp_n_q, dp_n_d;
    logic [NDIG-1:0]        an_n_q, an_n_d;
    logic                   tick_q, tick_d;
    logic [7*MAX_DIG-1:0]   in_flat;
    logic [6:0]             glyph_n;
    logic                   glyph_dp_n;
    logic                   sub_wrap, dwell_wrap, frame_wrap, blink_wrap, hide, lit;

    sevenseg_ext_n u_dec (
        .dig_i    (snap_q[idx_q]),
        .segs_n_o (glyph_n),
        .dp_n_o   (glyph_dp_n)
    );

    // Timebase, frame snapshot and next pin values; anodes stay dark until the first snapshot exists.
    always_comb begin
        sub_wrap    = sub_q == SW'(SLOT_LEN - 1);
        dwell_wrap  = sub_wrap && slot_q == 4'(PWM_SLOTS - 1);
        frame_wrap  = dwell_wrap && idx_q == IW'(NDIG - 1);
        blink_wrap  = blink_cnt_q == BW'(BLINK - 1);
        sub_d       = sub_wrap ? '0 : sub_q + 1'b1;
        slot_d      = sub_wrap ? slot_q + 1'b1 : slot_q;
        idx_d       = frame_wrap ? '0 : dwell_wrap ? idx_q + 1'b1 : idx_q;
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        phase_d     = phase_q ^ blink_wrap;
        valid_d     = valid_q | frame_wrap;
        in_flat     = '0;
        in_flat[DW-1:0] = digits;
        snap_d      = !frame_wrap ? snap_q : lz_en ? DW'(lz_suppress(in_flat, NDIG)) : digits;
        hide        = phase_q && blink_en[idx_q];
        lit         = valid_q && slot_q != '0 && slot_q <= bright;
        segs_n_d    = hide ? 7'h7F : glyph_n;
        dp_n_d      = hide | glyph_dp_n;
        an_n_d      = lit ? ~(NDIG'(1) << idx_q) : '1;
        tick_d      = frame_wrap;
    end

    // State and pin registers; reset blanks the pins and restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q       <= '0;
            slot_q      <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            valid_q     <= 1'b0;
            snap_q      <= {NDIG{BLANK_DIGIT}};
            segs_n_q    <= '1;
            dp_n_q      <= 1'b1;
            an_n_q      <= '1;
            tick_q      <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            snap_q      <= snap_d;
            segs_n_q    <= segs_n_d;
            dp_n_q      <= dp_n_d;
            an_n_q      <= an_n_d;
            tick_q      <= tick_d;
        end
    end

    assign segs_n     = segs_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// tb_sevenseg_scan_ctl: directed checks of scan order, PWM, zero blanking, blink, snapshot and reset
module tb_sevenseg_scan_ctl;

    localparam int NDIG  = 6;
    localparam int FRAME = 96;
    localparam int BLINK = 1600;
    localparam logic [6:0] G0 = 7'h40, G5 = 7'h12, G7 = 7'h78, GOFF = 7'h7F;

    logic              clk = 1'b0, rst = 1'b1, lz_en = 1'b0;
    logic [7*NDIG-1:0] digits = '0;
    logic [3:0]        bright = '0;
    logic [NDIG-1:0]   blink_en = '0;
    logic [6:0]        segs_n;
    logic              dp_n;
    logic [NDIG-1:0]   an_n;
    logic              frame_tick;
    int                cyc = 0, checks = 0, fails = 0;

    sevenseg_scan_ctl #(.NDIG(NDIG), .CLK_HZ(1_600_000), .DWELL_US(10), .BLINK_MS(1)) dut (
        .clk(clk), .rst(rst), .digits(digits), .bright(bright), .blink_en(blink_en),
        .lz_en(lz_en), .segs_n(segs_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached without summary, required earlier finish", $time);
        $fatal(1, "watchdog");
    end

    // Pins sampled after the n-th edge since reset release show scan position (n-1) mod FRAME.
    function automatic logic [NDIG-1:0] exp_an(int n, logic [3:0] br);
        int c = (n - 1) % FRAME;
        int s = c % 16;
        return (n > FRAME && s >= 1 && s <= int'(br)) ? ~(NDIG'(1) << (c / 16)) : '1;
    endfunction

    function automatic int cur_dig(int n);
        return ((n - 1) % FRAME) / 16;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_all(logic [6:0] v);
        for (int i = 0; i < NDIG; i++) digits[7*i +: 7] = v;
    endtask

    task automatic wait_tick(string tag);
        int i = 0;
        do begin step(); i++; end while (frame_tick !== 1'b1 && i < 200);
        checks++;
        if (frame_tick !== 1'b1) begin
            fails++;
            $display("FAIL %s_tick: frame_tick=%b after %0d cycles, required 1", tag, frame_tick, i);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; set_all(7'h05); bright = 4'd15;
        repeat (3) step();
        checks += 4;
        if (an_n !== '1) begin fails++; $display("FAIL reset_an: an_n=%b required 111111", an_n); end
        if (segs_n !== GOFF) begin fails++; $display("FAIL reset_segs: segs_n=%h required %h", segs_n, GOFF); end
        if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp: dp_n=%b required 1", dp_n); end
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: frame_tick=%b required 0", frame_tick); end
        rst = 1'b0;
        repeat (FRAME - 1) begin
            step();
            if (an_n !== '1 || frame_tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL pre_frame_dark: %0d lit or ticking cycles, required 0", bad); end
        step();
        checks += 2;
        if (frame_tick !== 1'b1) begin fails++; $display("FAIL first_tick: frame_tick=%b at cycle %0d, required 1", frame_tick, cyc); end
        if (an_n !== '1) begin fails++; $display("FAIL first_tick_an: an_n=%b required 111111", an_n); end
    endtask

    task automatic test_scan();
        logic [NDIG-1:0] e;
        for (int k = 0; k < FRAME; k++) begin
            step();
            e = exp_an(cyc, bright);
            checks += 2;
            if (an_n !== e) begin fails++; $display("FAIL scan_an cyc=%0d: an_n=%b required %b", cyc, an_n, e); end
            if (frame_tick !== (cyc % FRAME == 0)) begin fails++; $display("FAIL scan_tick cyc=%0d: frame_tick=%b", cyc, frame_tick); end
            if (e != '1) begin
                checks++;
                if (segs_n !== G5 || dp_n !== 1'b1) begin
                    fails++; $display("FAIL scan_glyph cyc=%0d: segs_n=%h dp_n=%b required %h 1", cyc, segs_n, dp_n, G5);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [NDIG-1:0] e;
        int lit [NDIG] = '{default: 0};
        bright = 4'd4;
        for (int k = 0; k < FRAME; k++) begin
            step();
            e = exp_an(cyc, 4'd4);
            checks++;
            if (an_n !== e) begin fails++; $display("FAIL pwm4_an cyc=%0d: an_n=%b required %b", cyc, an_n, e); end
            if (an_n !== '1) lit[cur_dig(cyc)]++;
        end
        for (int d = 0; d < NDIG; d++) begin
            checks++;
            if (lit[d] != 4) begin fails++; $display("FAIL pwm4_count d%0d: lit %0d cycles, required 4", d, lit[d]); end
        end
        bright = 4'd0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            checks++;
            if (an_n !== '1) begin fails++; $display("FAIL pwm0_an cyc=%0d: an_n=%b required 111111", cyc, an_n); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es [NDIG];
        logic       ed [NDIG];
        bright = 4'd15; lz_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            set_all(7'h00);
            digits[2*7 +: 7] = 7'h07;
            if (pass == 1) digits[4*7 +: 7] = 7'h20;
            es = pass == 0 ? '{G0, G0, G7, GOFF, GOFF, GOFF} : '{G0, G0, G7, G0, G0, GOFF};
            ed = pass == 0 ? '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1} : '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            wait_tick("lz");
            for (int k = 0; k < FRAME; k++) begin
                step();
                if (an_n !== '1) begin
                    checks++;
                    if (segs_n !== es[cur_dig(cyc)] || dp_n !== ed[cur_dig(cyc)]) begin
                        fails++;
                        $display("FAIL lz%0d_d%0d: segs_n=%h dp_n=%b required %h %b", pass, cur_dig(cyc),
                                 segs_n, dp_n, es[cur_dig(cyc)], ed[cur_dig(cyc)]);
                    end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blink();
        logic [NDIG-1:0] e;
        logic [6:0]      es;
        int              hidden = 0, shown = 0;
        set_all(7'h05); blink_en = 6'b000100;
        wait_tick("blink");
        for (int k = 0; k < 2 * BLINK + 200; k++) begin
            step();
            e = exp_an(cyc, 4'd15);
            checks++;
            if (an_n !== e) begin fails++; $display("FAIL blink_an cyc=%0d: an_n=%b required %b", cyc, an_n, e); end
            if (e != '1) begin
                es = (cur_dig(cyc) == 2 && ((cyc - 1) / BLINK) % 2 == 1) ? GOFF : G5;
                if (cur_dig(cyc) == 2) begin
                    if (es == GOFF) hidden++;
                    else shown++;
                end
                checks++;
                if (segs_n !== es || dp_n !== 1'b1) begin
                    fails++; $display("FAIL blink_glyph cyc=%0d d%0d: segs_n=%h required %h", cyc, cur_dig(cyc), segs_n, es);
                end
            end
        end
        checks += 2;
        if (hidden == 0) begin fails++; $display("FAIL blink_hidden: %0d hidden windows seen, required >0", hidden); end
        if (shown == 0) begin fails++; $display("FAIL blink_shown: %0d shown windows seen, required >0", shown); end
        blink_en = '0;
    endtask

    task automatic test_snapshot();
        int i = 0;
        wait_tick("snap_sync");
        repeat (40) step();
        set_all(7'h07);
        do begin
            step(); i++;
            if (an_n !== '1) begin
                checks++;
                if (segs_n !== G5) begin fails++; $display("FAIL snap_old cyc=%0d: segs_n=%h required %h", cyc, segs_n, G5); end
            end
        end while (frame_tick !== 1'b1 && i < 200);
        checks++;
        if (frame_tick !== 1'b1) begin fails++; $display("FAIL snap_tick: frame_tick=%b required 1", frame_tick); end
        step();
        checks += 2;
        if (segs_n !== G7) begin fails++; $display("FAIL snap_first: segs_n=%h required %h", segs_n, G7); end
        if (an_n !== '1) begin fails++; $display("FAIL snap_guard: an_n=%b required 111111", an_n); end
        repeat (FRAME - 1) begin
            step();
            if (an_n !== '1) begin
                checks++;
                if (segs_n !== G7) begin fails++; $display("FAIL snap_new cyc=%0d: segs_n=%h required %h", cyc, segs_n, G7); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NDIG-1:0] e;
        int bad = 0;
        wait_tick("rst_sync");
        repeat (20) step();
        rst = 1'b1;
        step();
        checks += 4;
        if (an_n !== '1) begin fails++; $display("FAIL mid_rst_an: an_n=%b required 111111", an_n); end
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL mid_rst_tick: frame_tick=%b required 0", frame_tick); end
        if (segs_n !== GOFF) begin fails++; $display("FAIL mid_rst_segs: segs_n=%h required %h", segs_n, GOFF); end
        if (dp_n !== 1'b1) begin fails++; $display("FAIL mid_rst_dp: dp_n=%b required 1", dp_n); end
        rst = 1'b0;
        repeat (FRAME - 1) begin
            step();
            if (an_n !== '1 || frame_tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL mid_rst_dark: %0d lit or ticking cycles, required 0", bad); end
        step();
        checks++;
        if (frame_tick !== 1'b1) begin fails++; $display("FAIL mid_rst_first_tick: frame_tick=%b at cycle %0d, required 1", frame_tick, cyc); end
        for (int k = 0; k < FRAME; k++) begin
            step();
            e = exp_an(cyc, 4'd15);
            checks++;
            if (an_n !== e) begin fails++; $display("FAIL mid_rst_an_scan cyc=%0d: an_n=%b required %b", cyc, an_n, e); end
            if (e != '1) begin
                checks++;
                if (segs_n !== G7) begin fails++; $display("FAIL mid_rst_glyph cyc=%0d: segs_n=%h required %h", cyc, segs_n, G7); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pwm();
        test_lz();
        test_blink();
        test_snapshot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctl.md
Name: sevenseg_scan_ctl

Overview:
Parametrised multiplexed seven-segment scan controller for Nexys-class boards, successor to the fixed 8-digit controller. It supports:
- any digit count
- a configurable per-digit dwell time
- 4-bit PWM brightness with an anti-ghosting guard slot
- per-digit blinking
- leading-zero suppression
- frame-synchronous input snapshotting, so a displayed frame never tears

It sits between application display logic and the board's cathode/anode pins.

Parameters:
NDIG, 8, number of digits scanned (2..16, need not be a power of 2)
CLK_HZ, 100_000_000, clk frequency in Hz
DWELL_US, 1000, time each digit is selected, in microseconds; DWELL = CLK_HZ/1_000_000*DWELL_US cycles, which must be a multiple of 16 and at least 16
BLINK_MS, 500, blink half-period in ms; BLINK = CLK_HZ/1000*BLINK_MS cycles

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
digits  in  7*NDIG  digit i at [7i+6:7i]; bit6 blank, bit5 dp, bit4 dash, bits3:0 hex value
bright  in  4  brightness 0..15; 0 means display off
blink_en  in  NDIG  digit i blinks when its bit is 1
lz_en  in  1  enables leading-zero suppression
segs_n  out  7  cathodes a..g, active low
dp_n  out  1  decimal-point cathode, active low
an_n  out  NDIG  anodes, active low, at most one low at a time
frame_tick  out  1  one-cycle pulse when a new frame snapshot is loaded

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - segs_n, dp_n and an_n all 1; frame_tick 0.
  - digit index 0, prescaler 0, blink timer 0, blink_phase 0 (visible).
  - Every snapshot entry set to BLANK_DIGIT (7'b100_0000).
  - Reset asserted mid-frame aborts the scan; the first snapshot is loaded at the first frame wrap after release.
- Prescaler counts 0..DWELL-1 and wraps. On the wrap, the digit index increments, and wraps NDIG-1 -> 0.
- Frame wrap: when the digit index goes from NDIG-1 to 0:
  - The snapshot register loads `digits` with leading-zero suppression applied.
  - frame_tick is registered high for exactly that one cycle.
  - Input changes therefore appear only from the next frame. Worst-case latency is NDIG*DWELL + 1 cycles.
- Leading-zero suppression, applied when lz_en=1 and evaluated at snapshot time:
  - A digit i (i >= 1) is "zero-plain" when blank=0, dash=0, dp=0 and value=0.
  - Digit i is stored as BLANK_DIGIT when it and every higher-index digit are zero-plain.
  - Digit 0 is never suppressed.
  - With lz_en=0, the snapshot is a straight copy.
- PWM within each dwell:
  - slot = prescaler / (DWELL/16), giving slots 0..15.
  - The selected anode is driven low only when 1 <= slot <= bright.
  - Slot 0 is always dark; this is the ghosting guard across digit changes.
  - bright=0 gives all anodes high. bright=15 gives 15/16 duty.
  - bright is sampled every cycle; a change takes effect within the current dwell.
- Blink:
  - The blink timer counts 0..BLINK-1; on its wrap, blink_phase toggles.
  - When blink_phase=1 and blink_en[digit]=1, the digit is shown as blank: segs_n and dp_n all 1.
  - Its anode still follows PWM.
- Decode of the selected snapshot entry:
  - blank=1 gives all segments off and dp off.
  - Otherwise dash=1 gives segment g only; otherwise the hex glyph is shown.
  - dp is lit when dp=1 and blank=0.
- Output timing:
  - All outputs are registered: pins reflect internal state (digit, slot, phase) with 1 cycle of latency.
  - segs_n, dp_n and an_n update on the same edge, so there are no skewed glyph/anode pairs.
- Simultaneous events:
  - A frame wrap coinciding with a blink toggle: both take effect on the same edge.
  - rst has priority over everything else.

Decomposition:
- Package sevenseg_pkg holds:
  - typedef digit_t, a packed struct {blank, dp, dash, logic [3:0] val}
  - constant BLANK_DIGIT
  - constant PWM_SLOTS = 16
  - function lz_suppress(), operating on a digit_t array
- Sub-module: sevenseg_ext_n (existing hex/dash/dp decoder), instantiated once on the muxed snapshot entry.
- Everything else is inline: prescaler, digit counter, blink timer, snapshot, output registers.

Test Plan:
Bench parameters: NDIG=6, CLK_HZ=1_600_000, DWELL_US=10 (DWELL=16, 1 cycle per slot), BLINK_MS=1 (BLINK=1600).
1. Reset, then release; all digits 7'h05, bright=15 -> no anode low before the first frame_tick; after it, an_n cycles 111110, 111101, ... 011111 each for 15 of 16 cycles; segs_n=7'b0010010 whenever an anode is low.
2. bright=4 -> each digit low for exactly 4 cycles per dwell (slots 1..4); bright=0 -> an_n stays 6'b111111 for a full frame.
3. lz_en=1, digits (d5..d0) = 0,0,0,7,0,0 -> d5..d3 blank; d2 shows 7; d1 and d0 show 0. Same input with d4.dp=1 -> only d5 blank.
4. blink_en=6'b000100 -> d2 glyph dark (segs_n=7'h7F) for alternating 1600-cycle windows; other digits unaffected.
5. Change `digits` mid-frame -> pins still show the old values until the next frame_tick; the new values appear on the cycle after it.
6. Assert rst for 1 cycle mid-dwell -> on the next edge an_n is all 1s and frame_tick is 0; the scan restarts at digit 0, and the display stays blank until a frame wrap.
